light_sequencer: RTL
====================

# light_sequencer

Phase sequencer that sits directly upstream of the light counter. It divides the system clock into a one-cycle countdown tick and drives the counter's `en` and one-hot `init` inputs. It consumes the counter's `last` flag and steps the lamp outputs GREEN → YELLOW → RED → GREEN. Its reset state matches the counter's reset load value, YELLOW, so the pair comes out of reset consistent without an initial load.

## Interface
Parameters:
- `pTICK_DIV`, default 100: system clocks per countdown tick; must be ≥ 2.
- `pDIV_WIDTH`, default `$clog2(pTICK_DIV)`: width of the prescaler.
- `pINIT_WIDTH`, default 3: width of `init_o`. Bit 0 is GREEN, bit 1 is YELLOW, bit 2 is RED.

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: when 0, the prescaler freezes and no ticks are issued.
- `last`, input, 1: counter-at-zero flag from the light counter.
- `night`, input, 1: night-flash request; used only when `LIGHT_NIGHT_FLASH_EN` is defined.
- `cnt_en_o`, output, 1: one-cycle tick pulse, drives the counter's `en`.
- `init_o`, output, `pINIT_WIDTH`: one-hot, one-cycle load pulse, drives the counter's `init`.
- `lamp_o`, output, 3: `{red, yellow, green}`, one-hot except in FLASH.
- `phase_o`, output, 2: encoded state. GREEN=0, YELLOW=1, RED=2, FLASH=3.

## Operation
Prescaler:
- `div_cnt` resets to 0 and increments while `run` is 1.
- At `pTICK_DIV-1` it wraps to 0, and `tick` is 1 in that cycle.
- `cnt_en_o` is `tick`, combinational from `div_cnt` and `run`.

State machine, states GREEN, YELLOW, RED (plus FLASH, see Configuration):
- Reset state is YELLOW.
- In a tick cycle with `last`=1, the state advances on the next edge:
  - GREEN → YELLOW
  - YELLOW → RED
  - RED → GREEN
- `init_o` is registered. It holds the one-hot bit of the new state for exactly the cycle following the transition edge, then returns to 0.
- Tick cycles with `last`=0 do not change the state.
- `lamp_o` is registered and decoded from the state: GREEN=3'b001, YELLOW=3'b010, RED=3'b100.
- Phase length in ticks is the counter init value + 1, because the counter's 0 is held for one tick.
- `run`=0 freezes everything except a pending `init_o` pulse, which still completes.

## Timing
- Reset values:
  - `div_cnt`=0, state=YELLOW
  - `init_o`=0, `cnt_en_o`=0
  - `lamp_o`=3'b010, `phase_o`=1
- First tick occurs in cycle `pTICK_DIV` after reset release, counting the first clock edge with `rst_n`=1 as cycle 1.
- Transition latency:
  - tick-with-`last` in cycle T.
  - `lamp_o`, `phase_o` and `init_o` change in cycle T+1.
  - The counter loads at the end of T+1, so `last` falls in T+2.
- Because `pTICK_DIV` ≥ 2, `init_o` never coincides with `cnt_en_o`. This requirement exists because the counter gives `init` priority and would drop a coincident tick.
- `last` is still 1 during cycle T+1. No second transition occurs because no tick arrives in T+1.
- Reset asserted mid-phase clears all state immediately and asynchronously. No `init_o` is issued on release. The counter is simultaneously reset to its YELLOW value.

## Configuration
Macro `LIGHT_NIGHT_FLASH_EN`.

Defined:
- `night`=1 sampled on any tick, in any normal state, moves the FSM to FLASH on the next edge.
- In FLASH:
  - `init_o`=0, and `cnt_en_o` is forced to 0.
  - `lamp_o` toggles between 3'b010 and 3'b000 on every tick, starting with 3'b010 on entry.
  - `phase_o`=3.
- `night`=0 sampled on a tick in FLASH moves the FSM to RED, with an `init_o`=3'b100 pulse in the next cycle.

Undefined:
- `night` is ignored and FLASH is unreachable.
- `phase_o` never equals 3.

## Test plan
All scenarios use `pTICK_DIV`=4 paired with the counter at GREEN 14, YELLOW 2, RED 17, with `run`=1 unless stated.
- Reset release → `lamp_o`=3'b010; ticks in cycles 4, 8, 12; `last`=1 at tick 12 → `lamp_o`=3'b100 and `init_o`=3'b100 in cycle 13, `init_o`=0 in cycle 14.
- Free-run a full cycle → GREEN lasts 15 ticks (60 clocks), YELLOW 3 ticks (12), RED 18 ticks (72); exactly one `init_o` pulse per phase; never more than one lamp lit at a time.
- `run`=0 for 20 clocks mid-RED → no `cnt_en_o`, `lamp_o` held at 3'b100; on resume, the next tick arrives 4 − (cycles already elapsed in the divider period) clocks later.
- `rst_n` pulsed low during GREEN with count 7 → outputs return to reset values asynchronously, within the same cycle; after release the sequence matches scenario 1.
- Check every cycle: `init_o` ≠ 0 never coincides with `cnt_en_o`=1.
- `LIGHT_NIGHT_FLASH_EN` defined, `night`=1 during GREEN → FLASH after the next tick; `lamp_o` alternates 010/000 every 4 clocks with `cnt_en_o` held 0. `night`=0 → RED with `init_o`=3'b100. Macro undefined: same stimulus leaves the normal sequence unchanged.

Source files
------------

// File: rtl/light_sequencer.sv
// Traffic-light phase sequencer: prescales clk into countdown ticks and steps GREEN/YELLOW/RED
// on the counter's last flag. Define LIGHT_NIGHT_FLASH_EN to enable the night flashing-yellow mode.
module light_sequencer #(
    parameter int pTICK_DIV   = 100,
    parameter int pDIV_WIDTH  = $clog2(pTICK_DIV),
    parameter int pINIT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   last,
    input  logic                   night,
    output logic                   cnt_en_o,
    output logic [pINIT_WIDTH-1:0] init_o,
    output logic [2:0]             lamp_o,
    output logic [1:0]             phase_o
);

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2,
        FLASH  = 2'd3
    } state_t;

    localparam logic [pDIV_WIDTH-1:0] DIV_LAST = pDIV_WIDTH'(pTICK_DIV - 1);

    state_t                state;
    state_t                nxt;
    logic                  load;
    logic                  tick;
    logic [pDIV_WIDTH-1:0] div_cnt;

    function automatic state_t succ(input state_t s);
        case (s)
            GREEN:   succ = YELLOW;
            YELLOW:  succ = RED;
            default: succ = GREEN;
        endcase
    endfunction

    function automatic logic [2:0] lamp_of(input state_t s);
        case (s)
            GREEN:   lamp_of = 3'b001;
            YELLOW:  lamp_of = 3'b010;
            RED:     lamp_of = 3'b100;
            default: lamp_of = 3'b010;
        endcase
    endfunction

    function automatic logic [pINIT_WIDTH-1:0] onehot(input state_t s);
        onehot = '0;
        case (s)
            GREEN:   onehot[0] = 1'b1;
            YELLOW:  onehot[1] = 1'b1;
            RED:     onehot[2] = 1'b1;
            default: onehot = '0;
        endcase
    endfunction

    assign tick = run && (div_cnt == DIV_LAST);

`ifdef LIGHT_NIGHT_FLASH_EN
    // The counter must stay frozen while flashing; the internal tick still paces the blink.
    assign cnt_en_o = tick && (state != FLASH);
`else
    logic unused_night;
    assign unused_night = night;
    assign cnt_en_o     = tick;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (run) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // Next state is only taken on a tick; load marks transitions that reload the counter.
    always_comb begin
        nxt  = state;
        load = 1'b0;
`ifdef LIGHT_NIGHT_FLASH_EN
        if (state == FLASH) begin
            if (!night) begin
                nxt  = RED;
                load = 1'b1;
            end
        end else if (night) begin
            nxt = FLASH;
        end else if (last) begin
            nxt  = succ(state);
            load = 1'b1;
        end
`else
        if (last) begin
            nxt  = succ(state);
            load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= YELLOW;
            init_o  <= '0;
            lamp_o  <= 3'b010;
            phase_o <= 2'd1;
        end else begin
            init_o <= (tick && load) ? onehot(nxt) : '0;
            if (tick) begin
                state   <= nxt;
                phase_o <= nxt;
                if (nxt == FLASH) begin
                    lamp_o <= (state == FLASH) ? (lamp_o ^ 3'b010) : 3'b010;
                end else begin
                    lamp_o <= lamp_of(nxt);
                end
            end
        end
    end

endmodule
